mem_bus_arbiter: RTL and testbench

- Sits directly downstream of each CPU's internal bus block.
- Collects read_q/write_q requests from NUM_CPU CPU ports and arbitrates them round-robin.
- Runs one transaction at a time against a single synchronous memory port, then returns a one-cycle read_dn/write_dn pulse and read data to the winner.
- Drives the shared bus_busy line and honours halt_q bus locking, which gives a CPU atomic multi-access sequences.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_rr_pick.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding, default
// bus widths and the round-robin distance helper.
package mem_bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    // Distance of idx after ptr in modulo-n order; the CPU right after ptr is 0.
    function automatic int rr_distance(input int idx, input int ptr, input int n);
        return (idx + 2 * n - 1 - ptr) % n;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first eligible requester
// after the pointer, with eligibility restricted by the lock mask.
module mem_bus_arbiter_rr_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_CPU = 2
) (
    input  logic [NUM_CPU-1:0] req,
    input  logic [2:0]         ptr,
    input  logic [NUM_CPU-1:0] lock_mask,
    output logic [2:0]         winner,
    output logic               valid
);

    logic [NUM_CPU-1:0] eligible;
    int                 best;

    assign eligible = req & lock_mask;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        best   = NUM_CPU;
        for (int c = 0; c < NUM_CPU; c++) begin
            if (eligible[c] && (rr_distance(c, int'(ptr), NUM_CPU) < best)) begin
                best   = rr_distance(c, int'(ptr), NUM_CPU);
                winner = 3'(c);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter running one transaction at a time from NUM_CPU CPU ports
// onto a single synchronous memory port, with halt_q bus locking and timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_CPU = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CPU-1:0]        cpu_read_q,
    input  logic [NUM_CPU-1:0]        cpu_write_q,
    input  logic [NUM_CPU-1:0]        cpu_halt_q,
    input  logic [NUM_CPU*ADDR_W-1:0] cpu_addr,
    input  logic [NUM_CPU*DATA_W-1:0] cpu_wdata,
    output logic [NUM_CPU-1:0]        cpu_read_dn,
    output logic [NUM_CPU-1:0]        cpu_write_dn,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      bus_busy,
    output logic [2:0]                grant_id,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_re,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack,
    output logic                      bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e          state, state_next;
    logic [2:0]          ptr;
    logic                lock;
    logic [CNT_W-1:0]    cnt;
    logic                lat_we;
    logic [DATA_W-1:0]   cap_data;

    logic [NUM_CPU-1:0]  owner_mask;
    logic [NUM_CPU-1:0]  lock_mask;
    logic                owner_halt;
    logic                timeout_hit;
    logic [2:0]          winner;
    logic                pick_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;

    assign owner_mask  = NUM_CPU'(1) << grant_id;
    assign owner_halt  = |(cpu_halt_q & owner_mask);
    assign lock_mask   = lock ? owner_mask : '1;
    assign timeout_hit = (cnt == CNT_LAST);
    assign bus_busy    = (state != ARB_IDLE) | lock;

    mem_bus_arbiter_rr_pick #(.NUM_CPU(NUM_CPU)) u_pick (
        .req       (cpu_read_q | cpu_write_q),
        .ptr       (ptr),
        .lock_mask (lock_mask),
        .winner    (winner),
        .valid     (pick_valid)
    );

    // A write wins over a read from the same CPU; the read stays pending.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int c = 0; c < NUM_CPU; c++) begin
            if (winner == 3'(c)) begin
                sel_addr  = cpu_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = cpu_wdata[c*DATA_W +: DATA_W];
                sel_we    = cpu_write_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        cpu_read_dn  = '0;
        cpu_write_dn = '0;
        cpu_rdata    = '0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) state_next = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                mem_re = ~lat_we;
                mem_we = lat_we;
                if (mem_ack || timeout_hit) state_next = ARB_DONE;
            end
            ARB_DONE: begin
                if (lat_we) begin
                    cpu_write_dn = owner_mask;
                end else begin
                    cpu_read_dn = owner_mask;
                    cpu_rdata   = cap_data;
                end
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // The lock is re-sampled from the owner's halt_q at the end of every
    // transaction and dropped in IDLE once the owner lets go of halt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 3'(NUM_CPU - 1);
            lock      <= 1'b0;
            cnt       <= '0;
            grant_id  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_we    <= 1'b0;
            cap_data  <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    lock <= lock & owner_halt;
                    cnt  <= '0;
                    if (pick_valid) begin
                        ptr       <= winner;
                        grant_id  <= winner;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        lat_we    <= sel_we;
                    end
                end
                ARB_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        cap_data <= mem_rdata;
                    end else if (timeout_hit) begin
                        cap_data <= '0;
                        bus_err  <= 1'b1;
                    end
                end
                ARB_DONE: begin
                    lock <= owner_halt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int NCPU = 2;
    localparam int TO   = 4;
    localparam logic [31:0] A_ADDR = 32'h0000_0010;
    localparam logic [31:0] B_ADDR = 32'h0000_0020;
    localparam logic [31:0] A_DATA = 32'h1111_1111;
    localparam logic [31:0] B_DATA = 32'h2222_2222;
    localparam logic [31:0] RD_VAL = 32'hDEAD_BEEF;

    logic        clk, rst;
    logic [1:0]  rq, wq, hq;
    logic [63:0] addr, wdata;
    logic [1:0]  read_dn, write_dn;
    logic [31:0] rdata;
    logic        busy;
    logic [2:0]  gid;
    logic [31:0] maddr, mwdata, mrdata;
    logic        mre, mwe, mack, berr;

    int total  = 0;
    int passed = 0;

    mem_bus_arbiter #(.NUM_CPU(NCPU), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_read_q   (rq),
        .cpu_write_q  (wq),
        .cpu_halt_q   (hq),
        .cpu_addr     (addr),
        .cpu_wdata    (wdata),
        .cpu_read_dn  (read_dn),
        .cpu_write_dn (write_dn),
        .cpu_rdata    (rdata),
        .bus_busy     (busy),
        .grant_id     (gid),
        .mem_addr     (maddr),
        .mem_wdata    (mwdata),
        .mem_re       (mre),
        .mem_we       (mwe),
        .mem_rdata    (mrdata),
        .mem_ack      (mack),
        .bus_err      (berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: re, we, rdn[1:0], wdn[1:0], busy, err
    typedef struct {
        logic        rst;
        logic [1:0]  rq, wq, hq;
        logic        ack;
        logic [31:0] mrd;
        logic [7:0]  e_ctl;
        logic [2:0]  e_gid;
        logic [31:0] e_rdata, e_addr, e_wdata;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic [1:0] q_r, q_w, q_h,
                                 input logic a, input logic [31:0] d, input logic [7:0] ctl,
                                 input logic [2:0] g, input logic [31:0] rd, ad, wd);
        vec_t v;
        v.rst = r; v.rq = q_r; v.wq = q_w; v.hq = q_h; v.ack = a; v.mrd = d;
        v.e_ctl = ctl; v.e_gid = g; v.e_rdata = rd; v.e_addr = ad; v.e_wdata = wd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic driveIn(input logic r, input logic [1:0] q_r, q_w, q_h,
                           input logic a, input logic [31:0] d);
        rst = r; rq = q_r; wq = q_w; hq = q_h; mack = a; mrdata = d;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveIn(v.rst, v.rq, v.wq, v.hq, v.ack, v.mrd);
        step();
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string n;
        n = $sformatf("vec%0d", idx);
        checkValue({n, "_ctl"}, {mre, mwe, read_dn, write_dn, busy, berr}, v.e_ctl);
        checkValue({n, "_gid"}, gid, v.e_gid);
        checkValue({n, "_rdata"}, rdata, v.e_rdata);
        checkValue({n, "_addr"}, maddr, v.e_addr);
        checkValue({n, "_wdata"}, mwdata, v.e_wdata);
    endtask

    // Transaction-level reference model
    int          m_ptr, m_gid, m_waited;
    bit          m_lock, m_active, m_finish, m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_data;

    task automatic modelStep();
        bit granted;
        if (rst) begin
            m_ptr = NCPU - 1; m_gid = 0; m_lock = 0; m_active = 0; m_finish = 0;
            m_we = 0; m_err = 0; m_addr = 0; m_wdata = 0; m_data = 0; m_waited = 0;
        end else if (m_finish) begin
            m_lock = hq[m_gid]; m_active = 0; m_finish = 0; m_err = 0;
        end else if (m_active) begin
            m_waited++;
            if (mack) begin
                m_data = mrdata; m_finish = 1;
            end else if (m_waited == TO) begin
                m_data = 0; m_finish = 1; m_err = 1;
            end
        end else begin
            granted = 0;
            for (int k = 1; k <= NCPU; k++) begin
                int c;
                c = (m_ptr + k) % NCPU;
                if (!granted && (rq[c] || wq[c]) && (!m_lock || c == m_gid)) begin
                    granted = 1;
                    m_lock  = m_lock && hq[m_gid];
                    m_ptr = c; m_gid = c; m_we = wq[c];
                    m_addr = addr[c*32 +: 32]; m_wdata = wdata[c*32 +: 32];
                    m_active = 1; m_waited = 0;
                end
            end
            if (!granted) m_lock = m_lock && hq[m_gid];
        end
    endtask

    vec_t        vecs[$];
    logic [1:0]  pend_r, pend_w, e_rdn, e_wdn;
    logic [31:0] e_rdata;

    initial begin
        driveIn(1, 0, 0, 0, 0, 0);
        addr  = {B_ADDR, A_ADDR};
        wdata = {B_DATA, A_DATA};

        // Single read, then two CPUs writing continuously
        vecs.push_back(mkv(1, 2'b00, 2'b00, 2'b00, 0, 0,      8'b00_00_00_0_0, 0, 0,      0,      0));
        vecs.push_back(mkv(0, 2'b01, 2'b00, 2'b00, 0, 0,      8'b10_00_00_1_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b01, 2'b00, 2'b00, 1, RD_VAL, 8'b00_01_00_1_0, 0, RD_VAL, A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b00, 0, RD_VAL, 8'b00_00_00_0_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(1, 2'b00, 2'b00, 2'b00, 0, 0,      8'b00_00_00_0_0, 0, 0,      0,      0));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b01_00_00_1_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b00_00_01_1_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b00_00_00_0_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b01_00_00_1_0, 1, 0,      B_ADDR, B_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b00_00_10_1_0, 1, 0,      B_ADDR, B_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b00_00_00_0_0, 1, 0,      B_ADDR, B_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b01_00_00_1_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 1, 0,      8'b00_00_01_1_0, 0, 0,      A_ADDR, A_DATA));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b00, 1, 0,      8'b00_00_00_0_0, 0, 0,      A_ADDR, A_DATA));

        step();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Lock: CPU1 holds halt_q across a write and a read while CPU0 waits
        driveIn(1, 2'b00, 2'b00, 2'b00, 1, 0); step();
        driveIn(0, 2'b00, 2'b10, 2'b10, 1, 0); step();
        checkValue("lock_w_gid", gid, 1);
        checkValue("lock_w_we", mwe, 1);
        driveIn(0, 2'b01, 2'b10, 2'b10, 1, 0); step();
        checkValue("lock_w_dn", write_dn, 2'b10);
        driveIn(0, 2'b11, 2'b00, 2'b10, 1, 32'h5A5A_5A5A); step();
        checkValue("lock_busy_idle", busy, 1);
        step();
        checkValue("lock_r_gid", gid, 1);
        checkValue("lock_r_re", mre, 1);
        checkValue("lock_r_addr", maddr, B_ADDR);
        step();
        checkValue("lock_r_dn", read_dn, 2'b10);
        checkValue("lock_r_data", rdata, 32'h5A5A_5A5A);
        driveIn(0, 2'b01, 2'b00, 2'b10, 1, 0); step();
        checkValue("lock_hold1", {busy, mre}, 2'b10);
        step();
        checkValue("lock_hold2", {busy, mre, gid}, {2'b10, 3'd1});
        driveIn(0, 2'b01, 2'b00, 2'b00, 1, 0); step();
        checkValue("lock_release", {busy, mre}, 2'b00);
        step();
        checkValue("lock_cpu0_grant", {mre, gid}, {1'b1, 3'd0});
        step();
        checkValue("lock_cpu0_dn", read_dn, 2'b01);
        driveIn(0, 0, 0, 0, 0, 0); step();

        // Timeout: no ack for TO access cycles
        driveIn(1, 0, 0, 0, 0, 0); step();
        driveIn(0, 2'b01, 2'b00, 2'b00, 0, 32'hFFFF_FFFF);
        for (int i = 0; i < TO; i++) begin
            step();
            checkValue($sformatf("to_wait%0d", i), {mre, berr, read_dn}, 4'b1000);
        end
        step();
        checkValue("to_abort", {berr, read_dn}, 3'b101);
        checkValue("to_rdata", rdata, 0);
        driveIn(0, 0, 0, 0, 0, 0); step();
        checkValue("to_err_clear", {berr, busy}, 2'b00);
        driveIn(0, 2'b01, 2'b00, 2'b00, 1, 32'h0000_1234); step(); step();
        checkValue("to_next_dn", {berr, read_dn}, 3'b001);
        checkValue("to_next_rdata", rdata, 32'h0000_1234);
        driveIn(0, 0, 0, 0, 0, 0); step();

        // Reset in the middle of an access
        driveIn(1, 0, 0, 0, 0, 0); step();
        driveIn(0, 2'b10, 2'b00, 2'b00, 0, 0); step();
        checkValue("rst_pre", {mre, gid}, {1'b1, 3'd1});
        driveIn(1, 2'b11, 2'b00, 2'b00, 0, 0); step();
        checkValue("rst_abandon", {mre, read_dn, busy, gid}, 7'd0);
        driveIn(0, 2'b11, 2'b00, 2'b00, 1, 32'h0000_CAFE); step();
        checkValue("rst_cpu0_first", {mre, gid}, {1'b1, 3'd0});
        step();
        checkValue("rst_cpu0_dn", read_dn, 2'b01);
        driveIn(0, 0, 0, 0, 0, 0); step();

        // Read and write together from CPU0: write is served first
        driveIn(1, 0, 0, 0, 0, 0); step();
        driveIn(0, 2'b01, 2'b01, 2'b00, 1, 32'hBEEF_0001); step();
        checkValue("rw_write_first", {mre, mwe}, 2'b01);
        step();
        checkValue("rw_wdn", {read_dn, write_dn}, 4'b0001);
        driveIn(0, 2'b01, 2'b00, 2'b00, 1, 32'hBEEF_0001); step();
        checkValue("rw_idle", mre, 0);
        step();
        checkValue("rw_read_next", mre, 1);
        step();
        checkValue("rw_rdn", read_dn, 2'b01);
        checkValue("rw_rdata", rdata, 32'hBEEF_0001);
        driveIn(0, 0, 0, 0, 0, 0); step();

        // Randomized traffic against the reference model
        pend_r = 0; pend_w = 0; hq = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCPU; c++) begin
                if (!pend_r[c] && !pend_w[c] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       pend_r[c] = 1'b1;
                        1:       pend_w[c] = 1'b1;
                        default: begin pend_r[c] = 1'b1; pend_w[c] = 1'b1; end
                    endcase
                    addr[c*32 +: 32]  = $urandom;
                    wdata[c*32 +: 32] = $urandom;
                end
                if ($urandom_range(0, 15) == 0) hq[c] = ~hq[c];
            end
            rq = pend_r; wq = pend_w;
            mack = ($urandom_range(0, 2) == 0);
            mrdata = $urandom;
            modelStep();
            step();
            e_rdn   = (m_finish && !m_we) ? 2'(1 << m_gid) : 2'b00;
            e_wdn   = (m_finish &&  m_we) ? 2'(1 << m_gid) : 2'b00;
            e_rdata = (m_finish && !m_we) ? m_data : 32'h0;
            checkValue("rnd_ctl", {mre, mwe, read_dn, write_dn, busy, berr, gid},
                       {m_active && !m_finish && !m_we, m_active && !m_finish && m_we,
                        e_rdn, e_wdn, m_active || m_lock, m_err, 3'(m_gid)});
            checkValue("rnd_rdata", rdata, e_rdata);
            checkValue("rnd_addr", maddr, m_addr);
            checkValue("rnd_wdata", mwdata, m_wdata);
            pend_r = pend_r & ~e_rdn;
            pend_w = pend_w & ~e_wdn;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
